phys_reg_free_list: RTL and testbench

- Supplies free physical register numbers to the rename (RNR) stage: up to two allocations per cycle, in program order.
- Takes back up to two released physical registers per cycle from commit (WB), i.e. each committing instruction's old destination mapping.
- Holds a speculative and a committed read pointer so branch-mispredict recovery restores the free list in one cycle.
- Sits directly upstream of RNR, beside the rename table; its outputs feed rs/rt/rd physical-number generation into RNR_RR_reg.

---
 rtl/phys_reg_free_list_pkg.sv | 13 +
 rtl/phys_reg_free_list_if.sv | 31 +++
 rtl/phys_reg_free_list_fl_ram_2r2w.sv | 33 +++
 rtl/phys_reg_free_list.sv | 91 +++++++++
 tb/tb_phys_reg_free_list.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phys_reg_free_list_pkg.sv
// rtl/phys_reg_free_list_pkg.sv - shared rename constants and types (package rename_pkg)
package rename_pkg;
    localparam int PREG_NUM = 64;
    localparam int AREG_NUM = 32;
    localparam int PREG_W   = 6;
    localparam int DEPTH    = PREG_NUM - AREG_NUM;
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int PTR_W    = IDX_W + 1;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [IDX_W-1:0]  idx_t;
endpackage

// File: rtl/phys_reg_free_list_if.sv
// rtl/phys_reg_free_list_if.sv - allocation/commit/free bundle between rename, commit and the free list
interface phys_reg_free_list_if;
    import rename_pkg::*;

    logic  alloc_req1;
    logic  alloc_req2;
    preg_t alloc_preg1;
    preg_t alloc_preg2;
    logic  alloc_stall;
    logic  commit_alloc1;
    logic  commit_alloc2;
    logic  free_en1;
    preg_t free_preg1;
    logic  free_en2;
    preg_t free_preg2;
    logic  recover;
    preg_t free_count;
    logic  fl_err;

    modport master (
        output alloc_req1, alloc_req2, commit_alloc1, commit_alloc2,
               free_en1, free_preg1, free_en2, free_preg2, recover,
        input  alloc_preg1, alloc_preg2, alloc_stall, free_count, fl_err
    );

    modport slave (
        input  alloc_req1, alloc_req2, commit_alloc1, commit_alloc2,
               free_en1, free_preg1, free_en2, free_preg2, recover,
        output alloc_preg1, alloc_preg2, alloc_stall, free_count, fl_err
    );
endinterface

// File: rtl/phys_reg_free_list_fl_ram_2r2w.sv
// rtl/phys_reg_free_list_fl_ram_2r2w.sv - DEPTH x PREG_W array, 2 async reads, 2 sync writes, reset to AREG_NUM+i
module fl_ram_2r2w
    import rename_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  idx_t  raddr0,
    input  idx_t  raddr1,
    output preg_t rdata0,
    output preg_t rdata1,
    input  logic  we0,
    input  idx_t  waddr0,
    input  preg_t wdata0,
    input  logic  we1,
    input  idx_t  waddr1,
    input  preg_t wdata1
);
    preg_t mem [DEPTH];

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= preg_t'(AREG_NUM + i);
            end
        end else begin
            if (we0) mem[waddr0] <= wdata0;
            if (we1) mem[waddr1] <= wdata1;
        end
    end
endmodule

// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - dual-issue physical register free list with one-cycle recovery; FREELIST_CHECK_EN enables fl_err checks
module phys_reg_free_list
    import rename_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    phys_reg_free_list_if.slave  fl
);
    ptr_t       spec_head;
    ptr_t       commit_head;
    ptr_t       tail;
    ptr_t       avail;
    logic [1:0] alloc_n;
    logic [1:0] commit_n;
    logic [1:0] free_n;
    logic       stall;
    idx_t       raddr0;
    idx_t       raddr1;
    preg_t      rdata0;
    preg_t      rdata1;

    assign alloc_n  = {1'b0, fl.alloc_req1} + {1'b0, fl.alloc_req2};
    assign commit_n = {1'b0, fl.commit_alloc1} + {1'b0, fl.commit_alloc2};
    assign free_n   = {1'b0, fl.free_en1} + {1'b0, fl.free_en2};

    // Extra wrap bit makes tail - spec_head span 0..DEPTH without ambiguity.
    assign avail         = tail - spec_head;
    assign fl.free_count = preg_t'(avail);
    assign stall         = fl.recover | (ptr_t'(alloc_n) > avail);
    assign fl.alloc_stall = stall;

    assign raddr0 = spec_head[IDX_W-1:0];
    assign raddr1 = raddr0 + idx_t'(1);

    assign fl.alloc_preg1 = rdata0;
    assign fl.alloc_preg2 = fl.alloc_req1 ? rdata1 : rdata0;

    fl_ram_2r2w u_ram (
        .clk    (clk),
        .rst    (rst),
        .raddr0 (raddr0),
        .raddr1 (raddr1),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .we0    (fl.free_en1 | fl.free_en2),
        .waddr0 (tail[IDX_W-1:0]),
        .wdata0 (fl.free_en1 ? fl.free_preg1 : fl.free_preg2),
        .we1    (fl.free_en1 & fl.free_en2),
        .waddr1 (tail[IDX_W-1:0] + idx_t'(1)),
        .wdata1 (fl.free_preg2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= ptr_t'(DEPTH);
        end else begin
            commit_head <= commit_head + ptr_t'(commit_n);
            tail        <= tail + ptr_t'(free_n);
            if (fl.recover) begin
                spec_head <= commit_head + ptr_t'(commit_n);
            end else if (!stall) begin
                spec_head <= spec_head + ptr_t'(alloc_n);
            end
        end
    end

`ifdef FREELIST_CHECK_EN
    logic err;
    logic full_free;
    logic zero_free;
    logic overrun;

    assign full_free = (free_n != 2'd0) && ((tail - commit_head) == ptr_t'(DEPTH));
    assign zero_free = (fl.free_en1 && fl.free_preg1 == '0) || (fl.free_en2 && fl.free_preg2 == '0);
    assign overrun   = ptr_t'(commit_n) > (spec_head - commit_head);

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (full_free || zero_free || overrun) begin
            err <= 1'b1;
        end
    end

    assign fl.fl_err = err;
`else
    assign fl.fl_err = 1'b0;
`endif
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb/tb_phys_reg_free_list.sv - directed and random checks of phys_reg_free_list against a queue model
module tb_phys_reg_free_list;
    import rename_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    phys_reg_free_list_if fl ();

    phys_reg_free_list dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl)
    );

    int checks   = 0;
    int failures = 0;

    // freeq: allocatable pregs in order; spec_q: allocated, not committed; busy: architecturally held
    int freeq[$];
    int spec_q[$];
    int busy[$];
    bit m_err;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        freeq.delete();
        spec_q.delete();
        busy.delete();
        for (int i = 0; i < DEPTH; i++) freeq.push_back(AREG_NUM + i);
        for (int i = 1; i < AREG_NUM; i++) busy.push_back(i);
        m_err = 1'b0;
    endtask

    function automatic int exp_err();
`ifdef FREELIST_CHECK_EN
        return int'(m_err);
`else
        return 0;
`endif
    endfunction

    task automatic drive(bit r1, bit r2, bit c1, bit c2, bit f1, int p1, bit f2, int p2, bit rec);
        fl.alloc_req1    = r1;
        fl.alloc_req2    = r2;
        fl.commit_alloc1 = c1;
        fl.commit_alloc2 = c2;
        fl.free_en1      = f1;
        fl.free_preg1    = preg_t'(p1);
        fl.free_en2      = f2;
        fl.free_preg2    = preg_t'(p2);
        fl.recover       = rec;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called at a negedge with inputs already driven; returns at the following negedge.
    task automatic step();
        int  n;
        int  fc;
        int  cn;
        int  pre_spec;
        bit  stall;
        bit  full;
        #1;
        n     = int'(fl.alloc_req1) + int'(fl.alloc_req2);
        fc    = freeq.size();
        stall = fl.recover || (n > fc);
        if (!rst) begin
            chk("free_count", fl.free_count, fc);
            chk("alloc_stall", fl.alloc_stall, stall);
            chk("fl_err", fl.fl_err, exp_err());
            if (!stall) begin
                if (fl.alloc_req1 && fl.alloc_req2) begin
                    chk("alloc_preg1", fl.alloc_preg1, freeq[0]);
                    chk("alloc_preg2", fl.alloc_preg2, freeq[1]);
                end else if (fl.alloc_req1) begin
                    chk("alloc_preg1", fl.alloc_preg1, freeq[0]);
                end else if (fl.alloc_req2) begin
                    chk("alloc_preg2_only", fl.alloc_preg2, freeq[0]);
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            full     = (freeq.size() + spec_q.size()) == DEPTH;
            cn       = int'(fl.commit_alloc1) + int'(fl.commit_alloc2);
            pre_spec = spec_q.size();
            if (((fl.free_en1 || fl.free_en2) && full) ||
                (fl.free_en1 && fl.free_preg1 == 0) ||
                (fl.free_en2 && fl.free_preg2 == 0) ||
                (cn > pre_spec)) m_err = 1'b1;
            repeat (cn) if (spec_q.size() > 0) busy.push_back(spec_q.pop_front());
            if (fl.recover) begin
                while (spec_q.size() > 0) freeq.push_front(spec_q.pop_back());
            end else if (!stall) begin
                repeat (n) spec_q.push_back(freeq.pop_front());
            end
            if (fl.free_en1) freeq.push_back(int'(fl.free_preg1));
            if (fl.free_en2) freeq.push_back(int'(fl.free_preg2));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        step();
        rst = 1'b0;

        // Reset state
        #1;
        chk("reset_free_count", fl.free_count, 32);
        chk("reset_stall", fl.alloc_stall, 0);
        chk("reset_err", fl.fl_err, 0);
        step();

        // First dual allocation
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("first_p1", fl.alloc_preg1, 32);
        chk("first_p2", fl.alloc_preg2, 33);
        step();
        #1 chk("first_count", fl.free_count, 30);

        // Drain to empty, then a single request stalls without moving spec_head
        repeat (15) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("empty_count", fl.free_count, 0);
        chk("empty_stall", fl.alloc_stall, 1);
        step();
        idle();
        step();

        // From one free entry: dual stalls, lone alloc_req2 takes the head entry
        do_reset();
        repeat (15) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("one_dual_stall", fl.alloc_stall, 1);
        step();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("one_req2_preg", fl.alloc_preg2, 63);
        step();
        idle();
        #1 chk("one_after_count", fl.free_count, 0);
        step();

        // Recovery to committed head
        do_reset();
        repeat (3) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
        step();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("recover_count", fl.free_count, 30);
        chk("recover_p1", fl.alloc_preg1, 34);
        chk("recover_p2", fl.alloc_preg2, 35);
        step();

        // Wrap: move spec_head to index 31 with an empty list, then refill with 5 and 9
        do_reset();
        repeat (15) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 15; i++) begin
            drive(0, 0, 1, 1, 1, 32 + 2 * i, 1, 33 + 2 * i, 0);
            step();
        end
        drive(0, 0, 1, 0, 1, 62, 0, 0, 0);
        step();
        repeat (16) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        drive(1, 1, 0, 0, 1, 5, 1, 9, 0);
        #1 chk("wrap_same_cycle_stall", fl.alloc_stall, 1);
        step();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("wrap_count", fl.free_count, 2);
        chk("wrap_p1", fl.alloc_preg1, 5);
        chk("wrap_p2", fl.alloc_preg2, 9);
        step();

        // Zero-preg free raises sticky fl_err only when checking is built in
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step();
        idle();
`ifdef FREELIST_CHECK_EN
        #1 chk("err_set", fl.fl_err, 1);
`else
        #1 chk("err_tied", fl.fl_err, 0);
`endif
        repeat (3) step();
        do_reset();
        #1 chk("err_cleared", fl.fl_err, 0);

        // Randomized legal traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bit r1, r2, c1, c2, f1, f2, rec;
            int p1, p2, nc, nf, room;
            rec  = ($urandom_range(15) == 0);
            r1   = 1'($urandom_range(1));
            r2   = 1'($urandom_range(1));
            nc   = $urandom_range(min2(2, spec_q.size()));
            c1   = (nc == 2) || (nc == 1 && $urandom_range(1) == 0);
            c2   = (nc == 2) || (nc == 1 && !c1);
            room = DEPTH - freeq.size() - spec_q.size();
            nf   = $urandom_range(min2(2, min2(room, busy.size())));
            f1   = (nf == 2) || (nf == 1 && $urandom_range(1) == 0);
            f2   = (nf == 2) || (nf == 1 && !f1);
            p1   = f1 ? busy.pop_front() : int'($urandom_range(63));
            p2   = f2 ? busy.pop_front() : int'($urandom_range(63));
            drive(r1, r2, c1, c2, f1, p1, f2, p2, rec);
            step();
        end

        // Reset overrides simultaneous traffic
        rst = 1'b1;
        drive(1, 1, 1, 1, 1, 7, 1, 8, 1);
        step();
        rst = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_override_count", fl.free_count, 32);
        chk("rst_override_p1", fl.alloc_preg1, 32);
        chk("rst_override_p2", fl.alloc_preg2, 33);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
